deep_host_if: RTL and testbench
===============================

// Module: deep_host_if
// PURPOSE
//  Host-side stream bridge for the neural-network top (deep). Deserializes an inbound
//  32-bit word stream (label, then 784 pixels) into the packed image/label bus and pulses
//  start. Waits for done, captures the 10 class scores and streams them back out.
//  Sits between the host link (UART/FIFO) and deep: the driving end of deep's start/done.
// PARAMETERS
//  NUM_PIXELS   784  pixel words per image
//  NUM_CLASSES  10   result words per inference
//  WORD_W       32   data word width (pixels, results)
//  LABEL_W      8    label width (low bits of first inbound word)
// PORTS
//  clk        in   1                       clock
//  rst        in   1                       synchronous reset, active-low
//  in_valid   in   1                       inbound word valid
//  in_ready   out  1                       inbound word accepted when valid&ready
//  in_data    in   WORD_W                  inbound word
//  image_out  out  NUM_PIXELS*WORD_W       packed image to deep.image_in (word i = pixel i)
//  label_out  out  LABEL_W                 label to deep.label_in
//  nn_start   out  1                       one-cycle start pulse to deep.start
//  nn_done    in   1                       deep.done
//  nn_result  in   NUM_CLASSES*WORD_W      deep.result, signed two's complement per word
//  out_valid  out  1                       outbound word valid
//  out_ready  in   1                       outbound word consumed when valid&ready
//  out_data   out  WORD_W                  outbound word
//  out_last   out  1                       marks final outbound word of a frame
//  busy       out  1                       high in every state except LOAD with count 0
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=LOAD, word count=0. All outputs 0 except in_ready=1.
//   image/label/result regs cleared. Reset mid-frame aborts; the partial frame is discarded.
//  States: LOAD -> START -> WAIT -> SEND -> LOAD.
//  LOAD: in_ready=1. Word 0 -> label_out = in_data[LABEL_W-1:0].
//   Words 1..NUM_PIXELS -> pixel (k-1). Count increments only on valid&ready.
//   On acceptance of word NUM_PIXELS: count->0, next state START. image_out/label_out hold
//   stable from then until the next frame's word 0 is accepted.
//  START: nn_start=1 for exactly one cycle; in_ready=0; -> WAIT.
//  WAIT: in_ready=0. The first cycle with nn_done=1 registers all of nn_result -> SEND.
//   nn_done seen in any other state is ignored. No timeout.
//  SEND: out_valid=1, out_data = result[idx], idx 0..NUM_CLASSES-1. idx advances on
//   out_valid&out_ready. out_data/out_last hold stable while stalled (out_ready=0).
//   After the last handshake: out_valid=0 on the next cycle -> LOAD, count=0.
//  Latency: nn_start asserts the cycle after the last pixel handshake. out_valid asserts
//   the cycle after nn_done is sampled.
//  Only in_ready gates input. in_data with in_valid=0 has no effect. in_ready is
//   registered-state-decoded (no combinational path from in_valid).
//  Count widths are $clog2(NUM_PIXELS+1) and $clog2(NUM_CLASSES+1). No wrap in either counter.
// CONFIGURATION
//  DEEP_ARGMAX_EN defined: after the NUM_CLASSES score words, SEND emits one extra word
//   = zero-extended index of the maximum signed score. On ties the lowest index wins.
//   out_last is asserted on this extra word only. The argmax is computed combinationally
//   in WAIT at capture time and registered alongside the scores.
//  Not defined: SEND emits exactly NUM_CLASSES words; out_last on word NUM_CLASSES-1;
//   no argmax logic is synthesized.
// STRUCTURE
//  Package deep_pkg: NUM_PIXELS, NUM_CLASSES, WORD_W, LABEL_W defaults;
//   typedef enum logic [1:0] {LOAD, START, WAIT, SEND} host_state_t;
//   typedef logic [WORD_W-1:0] word_t.
//  Sub-module deep_out_ser: result capture regs, SEND index counter, valid/ready/last
//   logic and the optional argmax. The parent keeps the FSM, the load counter and the
//   image/label regs.
// TESTING
//  1 Reset, then a frame with label=0x07 and pixel i=i, in_valid always 1 ->
//    label_out=7, image_out word 783=783, one nn_start pulse 1 cycle after the last word.
//  2 Random in_valid gaps (50%) during LOAD -> same image as test 1. Exactly 785
//    handshakes. in_ready stays 0 from START until SEND completes.
//  3 nn_done after 100 cycles with scores {5,-3,9,9,0,...} and out_ready toggling ->
//    10 words in order, stable under stall, out_last on word 9 (no _EN).
//  4 DEEP_ARGMAX_EN, same scores -> 11th word=0x00000002, out_last only on it.
//    With all scores negative and max at index 6 -> 6.
//  5 Reset asserted at pixel 400 -> in_ready=1, count=0, no nn_start. A full new frame
//    then works; nn_done pulsed in LOAD produces no out_valid.
//  6 Two back-to-back frames with out_ready=1 -> second frame loads right after the
//    first SEND. Results are not mixed between frames.

Source files
------------

// File: rtl/deep_pkg.sv
// Shared constants and types for the deep host bridge.
package deep_pkg;

    localparam int NUM_PIXELS  = 784;
    localparam int NUM_CLASSES = 10;
    localparam int WORD_W      = 32;
    localparam int LABEL_W     = 8;

    // Load counter spans 0..NUM_PIXELS (label word plus every pixel word).
    localparam int CNT_W = $clog2(NUM_PIXELS + 1);
    // Send index spans 0..NUM_CLASSES (room for the optional argmax word).
    localparam int IDX_W = $clog2(NUM_CLASSES + 1);

    typedef enum logic [1:0] {LOAD, START, WAIT, SEND} host_state_t;
    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/deep_out_ser.sv
// Result serializer for deep_host_if: captures the class scores when the
// network reports done, then streams them out over a valid/ready port.
// Build option DEEP_ARGMAX_EN appends the index of the largest signed score
// as one extra word, and out_last then moves to that word.
module deep_out_ser
    import deep_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          capture,
    input  logic [NUM_CLASSES*WORD_W-1:0] result_in,
    input  logic                          out_ready,
    output logic                          out_valid,
    output word_t                         out_data,
    output logic                          out_last,
    output logic                          frame_done
);

`ifdef DEEP_ARGMAX_EN
    localparam int NUM_WORDS = NUM_CLASSES + 1;
`else
    localparam int NUM_WORDS = NUM_CLASSES;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    word_t            score_reg [NUM_CLASSES];
    logic [IDX_W-1:0] idx_reg;
    logic             valid_reg;
    word_t            word_mux;
    logic             at_last;

`ifdef DEEP_ARGMAX_EN
    logic [IDX_W-1:0] argmax_next;
    logic [IDX_W-1:0] argmax_reg;
    word_t            best_score;

    // Largest signed score; strict compare keeps the lowest index on ties.
    always_comb begin
        argmax_next = '0;
        best_score  = result_in[WORD_W-1:0];
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if ($signed(result_in[i*WORD_W +: WORD_W]) > $signed(best_score)) begin
                best_score  = result_in[i*WORD_W +: WORD_W];
                argmax_next = IDX_W'(i);
            end
        end
    end

    // Argmax is registered in the same cycle as the scores.
    always_ff @(posedge clk) begin
        if (!rst)
            argmax_reg <= '0;
        else if (capture)
            argmax_reg <= argmax_next;
    end
`endif

    // Score capture on the done cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CLASSES; i++)
                score_reg[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < NUM_CLASSES; i++)
                score_reg[i] <= result_in[i*WORD_W +: WORD_W];
        end
    end

    // Output word select; driven only from registers so it holds under stall.
    always_comb begin
        word_mux = '0;
        if (idx_reg < IDX_W'(NUM_CLASSES))
            word_mux = score_reg[idx_reg];
`ifdef DEEP_ARGMAX_EN
        else
            word_mux = WORD_W'(argmax_reg);
`endif
    end

    assign at_last    = (idx_reg == LAST_IDX);
    assign out_valid  = valid_reg;
    assign out_data   = word_mux;
    assign out_last   = valid_reg && at_last;
    assign frame_done = valid_reg && out_ready && at_last;

    // Send index and valid: start on capture, advance per handshake, drop after the last word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            idx_reg   <= '0;
        end else if (capture) begin
            valid_reg <= 1'b1;
            idx_reg   <= '0;
        end else if (valid_reg && out_ready) begin
            if (at_last) begin
                valid_reg <= 1'b0;
                idx_reg   <= '0;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/deep_host_if.sv
// Host-side stream bridge for the deep network: deserializes label + pixels
// into the packed image bus, pulses start, waits for done and streams the
// class scores back out through deep_out_ser.
// Optional build macro DEEP_ARGMAX_EN (handled in deep_out_ser) adds an
// argmax word after the scores.
module deep_host_if
    import deep_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_W-1:0]             in_data,
    output logic [NUM_PIXELS*WORD_W-1:0]  image_out,
    output logic [LABEL_W-1:0]            label_out,
    output logic                          nn_start,
    input  logic                          nn_done,
    input  logic [NUM_CLASSES*WORD_W-1:0] nn_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_W-1:0]             out_data,
    output logic                          out_last,
    output logic                          busy
);

    host_state_t      state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             in_ready_reg;
    logic             nn_start_reg;
    logic [LABEL_W-1:0] label_reg;
    word_t            pixel_reg [NUM_PIXELS];

    logic in_hs;
    logic capture;
    logic frame_done;

    // in_ready is a register that is only high in LOAD, so a handshake implies LOAD.
    assign in_hs   = in_valid && in_ready_reg;
    assign capture = (state_reg == WAIT) && nn_done;

    // Label/pixel storage: word 0 is the label, word k is pixel k-1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            label_reg <= '0;
            for (int i = 0; i < NUM_PIXELS; i++)
                pixel_reg[i] <= '0;
        end else if (in_hs) begin
            if (count_reg == '0)
                label_reg <= in_data[LABEL_W-1:0];
            else
                pixel_reg[count_reg - 1'b1] <= in_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PIXELS; gi++) begin : g_image
            assign image_out[gi*WORD_W +: WORD_W] = pixel_reg[gi];
        end
    endgenerate

    // Control FSM with registered in_ready and start outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= LOAD;
            count_reg    <= '0;
            in_ready_reg <= 1'b1;
            nn_start_reg <= 1'b0;
        end else begin
            nn_start_reg <= 1'b0;
            case (state_reg)
                LOAD: begin
                    if (in_hs) begin
                        if (count_reg == CNT_W'(NUM_PIXELS)) begin
                            count_reg    <= '0;
                            in_ready_reg <= 1'b0;
                            nn_start_reg <= 1'b1;
                            state_reg    <= START;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                START: state_reg <= WAIT;
                WAIT: begin
                    if (nn_done)
                        state_reg <= SEND;
                end
                SEND: begin
                    if (frame_done) begin
                        in_ready_reg <= 1'b1;
                        state_reg    <= LOAD;
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

    deep_out_ser u_out_ser (
        .clk        (clk),
        .rst        (rst),
        .capture    (capture),
        .result_in  (nn_result),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    assign in_ready  = in_ready_reg;
    assign nn_start  = nn_start_reg;
    assign label_out = label_reg;
    assign busy      = !((state_reg == LOAD) && (count_reg == '0));

endmodule

// File: tb/tb_deep_host_if.sv
// Self-checking bench for deep_host_if: drives frames, plays the network's
// done/result side and scoreboards the outbound words.
// Define DEEP_ARGMAX_EN for both bench and RTL to cover the argmax word.
module tb_deep_host_if;
    import deep_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst = 1'b0;
    logic                          in_valid = 1'b0;
    logic                          in_ready;
    logic [WORD_W-1:0]             in_data = '0;
    logic [NUM_PIXELS*WORD_W-1:0]  image_out;
    logic [LABEL_W-1:0]            label_out;
    logic                          nn_start;
    logic                          nn_done = 1'b0;
    logic [NUM_CLASSES*WORD_W-1:0] nn_result = '0;
    logic                          out_valid;
    logic                          out_ready = 1'b0;
    logic [WORD_W-1:0]             out_data;
    logic                          out_last;
    logic                          busy;

    int    n_checks   = 0;
    int    n_errors   = 0;
    int    start_cnt  = 0;
    int    exp_starts = 0;
    word_t exp_q [$];

    word_t sc_a   [NUM_CLASSES];
    word_t sc_neg [NUM_CLASSES];
    word_t sc_b   [NUM_CLASSES];
    word_t sc_c   [NUM_CLASSES];

    deep_host_if dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .image_out (image_out),
        .label_out (label_out),
        .nn_start  (nn_start),
        .nn_done   (nn_done),
        .nn_result (nn_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Count start pulses mid-cycle.
    always @(negedge clk) if (nn_start) start_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic word_t word_of(input int k, input logic [7:0] lbl, input int salt);
        if (k == 0) return 32'h5A5A_5A00 | {24'h0, lbl};
        return word_t'(k - 1 + salt);
    endfunction

`ifdef DEEP_ARGMAX_EN
    function automatic word_t argmax_of(input word_t sc [NUM_CLASSES]);
        int b = 0;
        for (int i = 1; i < NUM_CLASSES; i++)
            if ($signed(sc[i]) > $signed(sc[b])) b = i;
        return word_t'(b);
    endfunction
`endif

    task automatic do_reset(input string tag);
        rst = 1'b0; in_valid = 1'b0; nn_done = 1'b0; out_ready = 1'b0;
        step(); step();
        check_eq({tag, "_rst_in_ready"}, in_ready, 1);
        check_eq({tag, "_rst_busy"}, busy, 0);
        check_eq({tag, "_rst_start"}, nn_start, 0);
        check_eq({tag, "_rst_out_valid"}, out_valid, 0);
        check_eq({tag, "_rst_out_last"}, out_last, 0);
        check_eq({tag, "_rst_out_data"}, out_data, 0);
        check_eq({tag, "_rst_label"}, label_out, 0);
        check_eq({tag, "_rst_pix783"}, image_out[783*WORD_W +: WORD_W], 0);
        rst = 1'b1;
        step();
    endtask

    // Feed words 0..target-1 with optional random valid gaps.
    task automatic load_words(input string tag, input logic [7:0] lbl, input int salt,
                              input int gap_pct, input int target);
        int k = 0;
        int cyc = 0;
        while (k < target && cyc < 20000) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? word_of(k, lbl, salt) : $urandom();
            @(negedge clk);
            if (in_valid && in_ready) k++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        in_data  = $urandom();
        check_eq({tag, "_handshakes"}, k, target);
        $display("%s: %0d words accepted in %0d cycles", tag, k, cyc);
    endtask

    // Called right after the last pixel handshake edge.
    task automatic check_frame(input string tag, input logic [7:0] lbl, input int salt);
        check_eq({tag, "_start_pulse"}, nn_start, 1);
        check_eq({tag, "_in_ready_start"}, in_ready, 0);
        check_eq({tag, "_busy_start"}, busy, 1);
        step();
        exp_starts++;
        check_eq({tag, "_start_one_cycle"}, nn_start, 0);
        check_eq({tag, "_start_count"}, start_cnt, exp_starts);
        check_eq({tag, "_label"}, label_out, lbl);
        check_eq({tag, "_pix0"}, image_out[0 +: WORD_W], word_t'(salt));
        check_eq({tag, "_pix400"}, image_out[400*WORD_W +: WORD_W], word_t'(400 + salt));
        check_eq({tag, "_pix783"}, image_out[783*WORD_W +: WORD_W], word_t'(783 + salt));
    endtask

    task automatic run_inference(input string tag, input word_t sc [NUM_CLASSES],
                                 input int delay, input bit toggle);
        int    viol = 0;
        int    stall_viol = 0;
        int    cyc = 0;
        int    nword = 0;
        bit    prev_stall = 1'b0;
        word_t prev_data = '0;
        logic  prev_last = 1'b0;
        word_t exp;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (in_ready || out_valid) viol++;
            step();
        end
        for (int i = 0; i < NUM_CLASSES; i++) begin
            exp_q.push_back(sc[i]);
            nn_result[i*WORD_W +: WORD_W] = sc[i];
        end
`ifdef DEEP_ARGMAX_EN
        exp_q.push_back(argmax_of(sc));
`endif
        nn_done = 1'b1;
        @(negedge clk);
        check_eq({tag, "_valid_before_done"}, out_valid, 0);
        step();
        nn_done = 1'b0;
        nn_result = '0;
        check_eq({tag, "_valid_latency"}, out_valid, 1);
        while (exp_q.size() > 0 && cyc < 2000) begin
            out_ready = toggle ? ((cyc == 0) ? 1'b0 : 1'($urandom_range(1))) : 1'b1;
            @(negedge clk);
            if (in_ready) viol++;
            if (out_valid) begin
                if (prev_stall && (out_data !== prev_data || out_last !== prev_last))
                    stall_viol++;
                if (out_ready) begin
                    exp = exp_q.pop_front();
                    $display("%s: word %0d data 0x%08h last %0b", tag, nword, out_data, out_last);
                    check_eq({tag, "_word"}, out_data, exp);
                    check_eq({tag, "_last"}, out_last, (exp_q.size() == 0));
                    nword++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = out_data;
                    prev_last  = out_last;
                end
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        check_eq({tag, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        check_eq({tag, "_valid_after"}, out_valid, 0);
        check_eq({tag, "_in_ready_after"}, in_ready, 1);
        check_eq({tag, "_busy_after"}, busy, 0);
        check_eq({tag, "_in_ready_low_viol"}, viol, 0);
        check_eq({tag, "_stall_viol"}, stall_viol, 0);
    endtask

    initial begin
        int done_viol;
        sc_a   = '{32'd5, -32'sd3, 32'd9, 32'd9, 32'd0, 32'd1, 32'd2, -32'sd7, 32'd4, 32'd3};
        sc_neg = '{-32'sd10, -32'sd20, -32'sd5, -32'sd30, -32'sd8, -32'sd9, -32'sd1, -32'sd2, -32'sd100, -32'sd3};
        sc_b   = '{32'h7FFF_FFFF, 32'd1, -32'sd1, 32'h8000_0000, 32'd0, 32'd12, 32'd13, 32'd14, 32'd15, 32'h7FFF_FFFF};
        sc_c   = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd500, 32'd600, 32'd700, 32'd800, 32'd900, 32'd1000};

        // Test 1: plain frame, in_valid always high.
        do_reset("t1");
        load_words("t1", 8'h07, 0, 0, NUM_PIXELS + 1);
        check_frame("t1", 8'h07, 0);
        // Test 3: late done, stalling consumer.
        run_inference("t3", sc_a, 100, 1'b1);

        // Test 2: 50% valid gaps, same image.
        load_words("t2", 8'h07, 0, 50, NUM_PIXELS + 1);
        check_frame("t2", 8'h07, 0);
        // Test 4 scores: all negative, maximum at index 6.
        run_inference("t4", sc_neg, 5, 1'b0);

        // Test 5: reset mid-frame, stray done in LOAD, then a full frame.
        load_words("t5a", 8'h99, 0, 0, 401);
        check_eq("t5_busy_midframe", busy, 1);
        do_reset("t5");
        check_eq("t5_no_start", start_cnt, exp_starts);
        nn_done = 1'b1;
        step();
        nn_done = 1'b0;
        done_viol = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) done_viol++;
            step();
        end
        check_eq("t5_done_in_load_ignored", done_viol, 0);
        load_words("t5b", 8'h3C, 7, 20, NUM_PIXELS + 1);
        check_frame("t5b", 8'h3C, 7);
        run_inference("t5", sc_b, 3, 1'b1);

        // Test 6: back-to-back frames with out_ready held high.
        load_words("t6a", 8'h21, 32'h1000, 0, NUM_PIXELS + 1);
        check_frame("t6a", 8'h21, 32'h1000);
        run_inference("t6a", sc_c, 2, 1'b0);
        load_words("t6b", 8'h42, 32'h2000, 0, NUM_PIXELS + 1);
        check_frame("t6b", 8'h42, 32'h2000);
        run_inference("t6b", sc_a, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
